// File: rtl/jt12_reg_wr_pkg.sv
// Shared constants for the jt12 CPU register writer: register map,
// strobe vector layout and small decode helpers.
package jt12_reg_wr_pkg;

    // Register map (part-relative addresses)
    localparam logic [7:0] REG_EFFECT  = 8'h27;  // CH3 mode / CSM
    localparam logic [7:0] REG_KEYON   = 8'h28;
    localparam logic [3:0] REG_OP_LO   = 4'h3;   // first operator group (DT1/MUL)
    localparam logic [3:0] REG_OP_HI   = 4'h9;   // last operator group (SSG-EG)
    localparam logic [7:0] REG_FNUMLO  = 8'hA0;
    localparam logic [7:0] REG_FNUMHI  = 8'hA4;
    localparam logic [7:0] REG_CH3LO   = 8'hA8;
    localparam logic [7:0] REG_CH3HI   = 8'hAC;
    localparam logic [7:0] REG_ALG     = 8'hB0;
    localparam logic [7:0] REG_PMS     = 8'hB4;

    // Bit positions inside the one-hot update strobe vector.
    // The operator strobes are contiguous and ordered by reg[7:4].
    typedef enum logic [3:0] {
        STB_KEYON   = 4'd0,
        STB_DT1     = 4'd1,
        STB_TL      = 4'd2,
        STB_KS_AR   = 4'd3,
        STB_AMEN_DR = 4'd4,
        STB_SR      = 4'd5,
        STB_SL_RR   = 4'd6,
        STB_SSGEG   = 4'd7,
        STB_FNUMLO  = 4'd8,
        STB_ALG     = 4'd9,
        STB_PMS     = 4'd10
    } stb_e;

    localparam int NUM_STB = 11;
    localparam int NUM_OPGRP = int'(REG_OP_HI) - int'(REG_OP_LO) + 1;

    // Number of clk_en ticks a strobe must be held so the store's slot
    // counter sweeps every channel/operator once.
    function automatic logic [4:0] hold_len(input int num_ch);
        return 5'(4 * num_ch);
    endfunction

    // CH3 special registers are laid out op3, op1, op2 by reg[1:0];
    // storage index is op1=0, op2=1, op3=2.
    function automatic logic [1:0] ch3_idx(input logic [1:0] lane);
        case (lane)
            2'd0:    return 2'd2;
            2'd1:    return 2'd0;
            default: return 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/jt12_reg_wr_dec.sv
// Combinational decode of the latched register address into channel,
// slot and a one-hot update strobe vector.
import jt12_reg_wr_pkg::*;

module jt12_wr_dec (
    input  logic [7:0]         sel_reg,
    input  logic               sel_part,
    input  logic               part_ok,   // low for part 1 on a 3-channel part
    output logic [2:0]         ch,
    output logic [1:0]         op,
    output logic [NUM_STB-1:0] strobe,
    output logic               valid
);

    // Lane 3 of every per-channel group is unmapped.
    logic lane_ok;
    assign lane_ok = part_ok && (sel_reg[1:0] != 2'b11);

    assign ch = {sel_part, sel_reg[1:0]};
    assign op = sel_reg[3:2];

    assign strobe[STB_KEYON]  = part_ok && (sel_reg == REG_KEYON);
    assign strobe[STB_FNUMLO] = lane_ok && (sel_reg[7:2] == REG_FNUMLO[7:2]);
    assign strobe[STB_ALG]    = lane_ok && (sel_reg[7:2] == REG_ALG[7:2]);
    assign strobe[STB_PMS]    = lane_ok && (sel_reg[7:2] == REG_PMS[7:2]);

    // One operator strobe per 0x30..0x90 group, selected by reg[7:4].
    generate
        for (genvar gi = 0; gi < NUM_OPGRP; gi++) begin : g_opgrp
            assign strobe[int'(STB_DT1) + gi] =
                lane_ok && (sel_reg[7:4] == 4'(int'(REG_OP_LO) + gi));
        end
    endgenerate

    assign valid = |strobe;

endmodule

// File: rtl/jt12_reg_wr.sv
// CPU-side register writer: latches address/data cycles, drives held
// update strobes for the register store and keeps the mode/latch state
// (fnum-high latch, CH3 special frequencies, CSM/effect bits).
import jt12_reg_wr_pkg::*;

module jt12_reg_wr #(
    parameter int num_ch = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        write,
    input  logic [1:0]  addr,
    input  logic [7:0]  cpu_din,
    output logic        busy,
    output logic [7:0]  din,
    output logic [2:0]  ch,
    output logic [1:0]  op,
    output logic        up_keyon,
    output logic        up_dt1,
    output logic        up_tl,
    output logic        up_ks_ar,
    output logic        up_amen_dr,
    output logic        up_sr,
    output logic        up_sl_rr,
    output logic        up_ssgeg,
    output logic        up_fnumlo,
    output logic        up_alg,
    output logic        up_pms,
    output logic [5:0]  latch_fnum,
    output logic        effect,
    output logic        csm,
    output logic [10:0] fnum_ch3op1,
    output logic [10:0] fnum_ch3op2,
    output logic [10:0] fnum_ch3op3,
    output logic [2:0]  block_ch3op1,
    output logic [2:0]  block_ch3op2,
    output logic [2:0]  block_ch3op3
);

    localparam logic       IS_3CH = (num_ch == 3);
    localparam logic [4:0] HOLD   = hold_len(num_ch);

    // Selected register and part from the last address cycle.
    // sel_p1 keeps the raw part bit so part-1 accesses on a 3-channel
    // part can be recognised and suppressed.
    logic [7:0]         sel_reg_q, sel_reg_d;
    logic               sel_part_q, sel_part_d;
    logic               sel_p1_q, sel_p1_d;

    logic [4:0]         cnt_q, cnt_d;
    logic [7:0]         din_q, din_d;
    logic [2:0]         ch_q, ch_d;
    logic [1:0]         op_q, op_d;
    logic [NUM_STB-1:0] stb_q, stb_d;

    logic [5:0]         latch_fnum_q, latch_fnum_d;
    logic               effect_q, effect_d;
    logic               csm_q, csm_d;
    logic [5:0]         hilatch_q [3];
    logic [5:0]         hilatch_d [3];
    logic [10:0]        fnum3_q [3];
    logic [10:0]        fnum3_d [3];
    logic [2:0]         block3_q [3];
    logic [2:0]         block3_d [3];

    logic [2:0]         dec_ch;
    logic [1:0]         dec_op;
    logic [NUM_STB-1:0] dec_stb;
    logic               dec_valid;
    logic               addr_wr;
    logic               data_wr;
    logic [1:0]         idx3;

    jt12_wr_dec u_dec (
        .sel_reg  (sel_reg_q),
        .sel_part (sel_part_q),
        .part_ok  (!(IS_3CH && sel_p1_q)),
        .ch       (dec_ch),
        .op       (dec_op),
        .strobe   (dec_stb),
        .valid    (dec_valid)
    );

    assign busy    = (cnt_q != 5'd0);
    assign addr_wr = write && !addr[0];
    assign data_wr = write && addr[0] && !busy;
    assign idx3    = ch3_idx(sel_reg_q[1:0]);

    // Next-state: address latch, data capture, hold countdown and mode latches.
    always_comb begin
        sel_reg_d    = sel_reg_q;
        sel_part_d   = sel_part_q;
        sel_p1_d     = sel_p1_q;
        cnt_d        = cnt_q;
        din_d        = din_q;
        ch_d         = ch_q;
        op_d         = op_q;
        stb_d        = stb_q;
        latch_fnum_d = latch_fnum_q;
        effect_d     = effect_q;
        csm_d        = csm_q;
        hilatch_d    = hilatch_q;
        fnum3_d      = fnum3_q;
        block3_d     = block3_q;

        if (addr_wr) begin
            sel_reg_d  = cpu_din;
            sel_part_d = addr[1] && !IS_3CH;
            sel_p1_d   = addr[1];
        end

        if (data_wr) begin
            // Load wins over a simultaneous clk_en decrement.
            cnt_d = HOLD;
            din_d = cpu_din;
            ch_d  = dec_ch;
            op_d  = dec_op;
            stb_d = dec_valid ? dec_stb : '0;

            if (sel_reg_q == REG_EFFECT) begin
                effect_d = (cpu_din[7:6] != 2'b00);
                csm_d    = (cpu_din[7:6] == 2'b10);
            end
            if (sel_reg_q[1:0] != 2'b11) begin
                if (sel_reg_q[7:2] == REG_FNUMHI[7:2])
                    latch_fnum_d = cpu_din[5:0];
                if (sel_reg_q[7:2] == REG_CH3HI[7:2])
                    hilatch_d[idx3] = cpu_din[5:0];
                if (sel_reg_q[7:2] == REG_CH3LO[7:2])
                    {block3_d[idx3], fnum3_d[idx3]} = {hilatch_q[idx3], cpu_din};
            end
        end else if (clk_en && busy) begin
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1)
                stb_d = '0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_reg_q    <= '0;
            sel_part_q   <= 1'b0;
            sel_p1_q     <= 1'b0;
            cnt_q        <= '0;
            din_q        <= '0;
            ch_q         <= '0;
            op_q         <= '0;
            stb_q        <= '0;
            latch_fnum_q <= '0;
            effect_q     <= 1'b0;
            csm_q        <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                hilatch_q[i] <= '0;
                fnum3_q[i]   <= '0;
                block3_q[i]  <= '0;
            end
        end else begin
            sel_reg_q    <= sel_reg_d;
            sel_part_q   <= sel_part_d;
            sel_p1_q     <= sel_p1_d;
            cnt_q        <= cnt_d;
            din_q        <= din_d;
            ch_q         <= ch_d;
            op_q         <= op_d;
            stb_q        <= stb_d;
            latch_fnum_q <= latch_fnum_d;
            effect_q     <= effect_d;
            csm_q        <= csm_d;
            hilatch_q    <= hilatch_d;
            fnum3_q      <= fnum3_d;
            block3_q     <= block3_d;
        end
    end

    assign din        = din_q;
    assign ch         = ch_q;
    assign op         = op_q;
    assign up_keyon   = stb_q[STB_KEYON];
    assign up_dt1     = stb_q[STB_DT1];
    assign up_tl      = stb_q[STB_TL];
    assign up_ks_ar   = stb_q[STB_KS_AR];
    assign up_amen_dr = stb_q[STB_AMEN_DR];
    assign up_sr      = stb_q[STB_SR];
    assign up_sl_rr   = stb_q[STB_SL_RR];
    assign up_ssgeg   = stb_q[STB_SSGEG];
    assign up_fnumlo  = stb_q[STB_FNUMLO];
    assign up_alg     = stb_q[STB_ALG];
    assign up_pms     = stb_q[STB_PMS];
    assign latch_fnum = latch_fnum_q;
    assign effect     = effect_q;
    assign csm        = csm_q;

    assign fnum_ch3op1  = fnum3_q[0];
    assign fnum_ch3op2  = fnum3_q[1];
    assign fnum_ch3op3  = fnum3_q[2];
    assign block_ch3op1 = block3_q[0];
    assign block_ch3op2 = block3_q[1];
    assign block_ch3op3 = block3_q[2];

endmodule

// File: tb/tb_jt12_reg_wr.sv
// Directed bench for jt12_reg_wr: a 6-channel and a 3-channel instance
// share the same CPU bus; expected values are hand-computed.
module tb_jt12_reg_wr;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_en = 1'b0;
    logic       write = 1'b0;
    logic [1:0] addr = 2'b00;
    logic [7:0] cpu_din = 8'h00;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // 6-channel instance outputs
    logic        busy6;
    logic [7:0]  din6;
    logic [2:0]  ch6;
    logic [1:0]  op6;
    logic        k6, dt6, tl6, ks6, am6, sr6, sl6, ssg6, flo6, alg6, pms6;
    logic [5:0]  lf6;
    logic        eff6, csm6;
    logic [10:0] f1_6, f2_6, f3_6;
    logic [2:0]  b1_6, b2_6, b3_6;

    // 3-channel instance outputs
    logic        busy3;
    logic [7:0]  din3;
    logic [2:0]  ch3;
    logic [1:0]  op3;
    logic        k3, dt3, tl3, ks3, am3, sr3, sl3, ssg3, flo3, alg3, pms3;
    logic [5:0]  lf3;
    logic        eff3, csm3;
    logic [10:0] f1_3, f2_3, f3_3;
    logic [2:0]  b1_3, b2_3, b3_3;

    jt12_reg_wr #(.num_ch(6)) dut6 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .write(write), .addr(addr), .cpu_din(cpu_din),
        .busy(busy6), .din(din6), .ch(ch6), .op(op6),
        .up_keyon(k6), .up_dt1(dt6), .up_tl(tl6), .up_ks_ar(ks6), .up_amen_dr(am6),
        .up_sr(sr6), .up_sl_rr(sl6), .up_ssgeg(ssg6), .up_fnumlo(flo6), .up_alg(alg6), .up_pms(pms6),
        .latch_fnum(lf6), .effect(eff6), .csm(csm6),
        .fnum_ch3op1(f1_6), .fnum_ch3op2(f2_6), .fnum_ch3op3(f3_6),
        .block_ch3op1(b1_6), .block_ch3op2(b2_6), .block_ch3op3(b3_6)
    );

    jt12_reg_wr #(.num_ch(3)) dut3 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .write(write), .addr(addr), .cpu_din(cpu_din),
        .busy(busy3), .din(din3), .ch(ch3), .op(op3),
        .up_keyon(k3), .up_dt1(dt3), .up_tl(tl3), .up_ks_ar(ks3), .up_amen_dr(am3),
        .up_sr(sr3), .up_sl_rr(sl3), .up_ssgeg(ssg3), .up_fnumlo(flo3), .up_alg(alg3), .up_pms(pms3),
        .latch_fnum(lf3), .effect(eff3), .csm(csm3),
        .fnum_ch3op1(f1_3), .fnum_ch3op2(f2_3), .fnum_ch3op3(f3_3),
        .block_ch3op1(b1_3), .block_ch3op2(b2_3), .block_ch3op3(b3_3)
    );

    // Strobe vectors: bit0 keyon, 1 dt1, 2 tl, 3 ks_ar, 4 amen_dr, 5 sr,
    // 6 sl_rr, 7 ssgeg, 8 fnumlo, 9 alg, 10 pms
    logic [10:0] stb6, stb3;
    assign stb6 = {pms6, alg6, flo6, ssg6, sl6, sr6, am6, ks6, tl6, dt6, k6};
    assign stb3 = {pms3, alg3, flo3, ssg3, sl3, sr3, am3, ks3, tl3, dt3, k3};

    localparam logic [10:0] S_NONE  = 11'h000;
    localparam logic [10:0] S_KEYON = 11'h001;
    localparam logic [10:0] S_DT1   = 11'h002;
    localparam logic [10:0] S_TL    = 11'h004;
    localparam logic [10:0] S_KSAR  = 11'h008;
    localparam logic [10:0] S_FLO   = 11'h100;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Bus write; starts and ends at a falling edge, one rising edge in between.
    task automatic wr(input logic [1:0] a, input logic [7:0] d, input logic en);
        write   = 1'b1;
        addr    = a;
        cpu_din = d;
        clk_en  = en;
        @(negedge clk);
        write   = 1'b0;
        clk_en  = 1'b0;
    endtask

    // n clk_en ticks, each followed by an idle clock.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            clk_en = 1'b1;
            @(negedge clk);
            clk_en = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_busy6",  32'(busy6), 32'd0);
        check("rst_busy3",  32'(busy3), 32'd0);
        check("rst_din",    32'(din6),  32'd0);
        check("rst_stb",    32'(stb6),  32'd0);
        check("rst_latch",  32'(lf6),   32'd0);
        check("rst_effect", 32'({eff6, csm6}), 32'd0);
        check("rst_ch3op1", 32'(f1_6),  32'd0);

        // TL write: 0x42 <- 0x1F
        wr(2'b00, 8'h42, 1'b0);
        wr(2'b01, 8'h1F, 1'b0);
        check("tl_stb",  32'(stb6), 32'(S_TL));
        check("tl_ch",   32'(ch6),  32'd2);
        check("tl_op",   32'(op6),  32'd0);
        check("tl_din",  32'(din6), 32'h1F);
        check("tl_busy", 32'(busy6), 32'd1);
        check("tl_stb3", 32'(stb3), 32'(S_TL));
        tick(11);
        check("tl_busy3_t11", 32'(busy3), 32'd1);
        tick(1);
        check("tl_busy3_t12", 32'(busy3), 32'd0);
        check("tl_stb3_t12",  32'(stb3),  32'(S_NONE));
        check("tl_busy6_t12", 32'(busy6), 32'd1);
        tick(11);
        check("tl_stb_t23",  32'(stb6),  32'(S_TL));
        check("tl_busy_t23", 32'(busy6), 32'd1);
        tick(1);
        check("tl_busy_t24", 32'(busy6), 32'd0);
        check("tl_stb_t24",  32'(stb6),  32'(S_NONE));
        check("tl_din_t24",  32'(din6),  32'h1F);

        // Part 1: 0x3D <- 0x71
        wr(2'b10, 8'h3D, 1'b0);
        wr(2'b11, 8'h71, 1'b0);
        check("p1_stb",   32'(stb6),  32'(S_DT1));
        check("p1_ch",    32'(ch6),   32'd5);
        check("p1_op",    32'(op6),   32'd3);
        check("p1_din",   32'(din6),  32'h71);
        check("p1_stb3",  32'(stb3),  32'(S_NONE));
        check("p1_busy3", 32'(busy3), 32'd1);
        tick(11);
        check("p1_busy3_t11", 32'(busy3), 32'd1);
        tick(1);
        check("p1_busy3_t12", 32'(busy3), 32'd0);
        tick(12);
        check("p1_busy6_t24", 32'(busy6), 32'd0);

        // Fnum pair: 0xA4 <- 0x22, 0xA0 <- 0x55
        wr(2'b00, 8'hA4, 1'b0);
        wr(2'b01, 8'h22, 1'b0);
        check("fhi_latch", 32'(lf6),   32'h22);
        check("fhi_stb",   32'(stb6),  32'(S_NONE));
        check("fhi_busy",  32'(busy6), 32'd1);
        tick(24);
        wr(2'b00, 8'hA0, 1'b0);
        wr(2'b01, 8'h55, 1'b0);
        check("flo_stb",   32'(stb6), 32'(S_FLO));
        check("flo_ch",    32'(ch6),  32'd0);
        check("flo_din",   32'(din6), 32'h55);
        check("flo_latch", 32'(lf6),  32'h22);
        tick(24);

        // CH3 special: 0xAD <- 0x1B, 0xA9 <- 0x80, 0x27 <- 0x40, 0x27 <- 0x80
        wr(2'b00, 8'hAD, 1'b0);
        wr(2'b01, 8'h1B, 1'b0);
        tick(24);
        wr(2'b00, 8'hA9, 1'b0);
        wr(2'b01, 8'h80, 1'b0);
        check("ch3_fnum1",  32'(f1_6), 32'h380);
        check("ch3_block1", 32'(b1_6), 32'd3);
        check("ch3_fnum3",  32'(f3_6), 32'h000);
        tick(24);
        wr(2'b00, 8'h27, 1'b0);
        wr(2'b01, 8'h40, 1'b0);
        check("mode40_effect", 32'(eff6), 32'd1);
        check("mode40_csm",    32'(csm6), 32'd0);
        tick(24);
        wr(2'b00, 8'h27, 1'b0);
        wr(2'b01, 8'h80, 1'b0);
        check("mode80_effect", 32'(eff6), 32'd1);
        check("mode80_csm",    32'(csm6), 32'd1);
        tick(24);

        // Dropped writes: mid-hold and on the expiry edge
        wr(2'b00, 8'h42, 1'b0);
        wr(2'b01, 8'h1F, 1'b0);
        tick(5);
        wr(2'b00, 8'h55, 1'b0);
        wr(2'b01, 8'hAA, 1'b0);
        check("drop_din", 32'(din6), 32'h1F);
        check("drop_stb", 32'(stb6), 32'(S_TL));
        check("drop_ch",  32'(ch6),  32'd2);
        tick(18);
        check("drop_busy_t23", 32'(busy6), 32'd1);
        wr(2'b01, 8'h77, 1'b1);
        check("expiry_busy", 32'(busy6), 32'd0);
        check("expiry_din",  32'(din6),  32'h1F);
        check("expiry_stb",  32'(stb6),  32'(S_NONE));
        // Accepted write with coincident clk_en: load wins, full 24 ticks follow
        wr(2'b01, 8'h66, 1'b1);
        check("after_stb", 32'(stb6), 32'(S_KSAR));
        check("after_din", 32'(din6), 32'h66);
        check("after_ch",  32'(ch6),  32'd1);
        check("after_op",  32'(op6),  32'd1);
        tick(23);
        check("prio_busy_t23", 32'(busy6), 32'd1);
        tick(1);
        check("prio_busy_t24", 32'(busy6), 32'd0);

        // Reset mid-hold
        wr(2'b00, 8'h42, 1'b0);
        wr(2'b01, 8'h1F, 1'b0);
        tick(10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_busy",  32'(busy6), 32'd0);
        check("mrst_stb",   32'(stb6),  32'(S_NONE));
        check("mrst_din",   32'(din6),  32'd0);
        check("mrst_latch", 32'(lf6),   32'd0);
        check("mrst_mode",  32'({eff6, csm6}), 32'd0);
        check("mrst_ch3",   32'(f1_6),  32'd0);
        wr(2'b00, 8'h28, 1'b0);
        wr(2'b01, 8'hF1, 1'b0);
        check("post_stb",  32'(stb6),  32'(S_KEYON));
        check("post_din",  32'(din6),  32'hF1);
        check("post_busy", 32'(busy6), 32'd1);
        tick(24);
        check("post_busy_t24", 32'(busy6), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
